muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit producing the HI/LO pair. Reuses the team's combinational `ALU` (add `4'b0010` / subtract `4'b0110`) as its only adder. It sequences 32 shift-add or restoring-divide iterations through that ALU, plus operand/result negation steps for signed ops. It sits beside the EX stage; the core stalls on `busy_sig` and latches HI/LO on `done_sig`.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start_sig`  in  1  request; accepted only in IDLE
- `op_sig`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `operand_a`  in  32  multiplicand / dividend
- `operand_b`  in  32  multiplier / divisor
- `busy_sig`  out  1  operation in progress
- `done_sig`  out  1  one-cycle completion pulse
- `hi_out`  out  32  product[63:32] / remainder
- `lo_out`  out  32  product[31:0] / quotient

## Operation
- **States:** IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE.
- **Reset:**
  - state IDLE.
  - `busy_sig`=0, `done_sig`=0, `hi_out`=`lo_out`=0.
  - Iteration counter 0.
  - Reset mid-operation aborts with no output update beyond the clear.
- **Accept:** IDLE & `start_sig` latches `op_sig`, `operand_a`, `operand_b`, and the signs of both operands.
- **Divide by zero:** for DIV/DIVU with `operand_b`==0, go directly to DONE with `lo`=FFFF_FFFF, `hi`=`operand_a`.
- **Signed ops** always visit NEG_A and NEG_B.
  - NEG_A: ALU sub 0-a; the result is kept only if a is negative.
  - NEG_B: same, for b.
- **Unsigned ops** go IDLE→ITER.
- **ITER, multiply** (hi=0, lo=b, M=a at entry):
  - ALU add, `data_1`=hi, `data_2`= lo[0] ? M : 0.
  - carry = result < hi (unsigned).
  - {hi,lo} ← {carry, result, lo[31:1]}.
- **ITER, divide** (hi=0, lo=a, D=b):
  - ALU sub, `data_1`=s={hi[30:0],lo[31]}, `data_2`=D.
  - ge = hi[31] | (s ≥ D).
  - If ge: hi←result and lo←{lo[30:0],1}. Otherwise: hi←s and lo←{lo[30:0],0}.
- **Iteration count:** ITER runs exactly 32 cycles; the counter is 6 bits and wraps to 0 on exit.
- **Result negation for MULT:** applied when sign_a≠sign_b.
  - NEG_LO: lo←0-lo; latch lo_was_zero.
  - NEG_HI: ALU add, ~hi + lo_was_zero.
- **Result negation for DIV:**
  - NEG_LO: lo←0-lo if sign_a≠sign_b.
  - NEG_HI: hi←0-hi if sign_a.
- **Negation not required:** registers hold, but the ALU is still driven. Latency is fixed.
- **DIV 0x8000_0000 / -1:** lo=8000_0000, hi=0 (wraps, no trap).
- **Idle ALU drive:** in IDLE/DONE the ALU is driven with add, 0, 0.
- **Allowed ALU controls:** only `4'b0010` and `4'b0110` are ever issued.
- **Output hold:** `hi_out`/`lo_out` hold their last result until the next accepted start.
- **`start_sig` while busy:** ignored.

## Timing
- Start accepted at cycle T.
- `busy_sig` is high from T+1 through the DONE cycle inclusive.
- `done_sig` is high only in the DONE cycle; results are valid from the DONE cycle.
- Unsigned: ITER T+1..T+32, DONE T+33.
- Signed:
  - NEG_A T+1, NEG_B T+2.
  - ITER T+3..T+34.
  - NEG_LO T+35, NEG_HI T+36.
  - DONE T+37.
- Divide by zero: DONE T+1.
- DONE→IDLE unconditionally; a new start is accepted at T+34 (unsigned) at the earliest.
- All outputs are registered. The ALU path is combinational within one cycle.

## Structure
- **Shared package `mips_pkg`:**
  - ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV.
  - sequencer state enum.
- **One sub-module:** an instance of the existing `ALU`.
  - `ALU_Control_sig`, `data_1`, `data_2` are driven from state.
  - `ALU_result` is consumed; `zero_sig` is unused.

## Test plan
- MULTU FFFF_FFFF×FFFF_FFFF → hi=FFFF_FFFE, lo=0000_0001, `done_sig` at T+33.
- MULT −3×7 → hi=FFFF_FFFF, lo=FFFF_FFEB at T+37; MULT −1×0 → hi=lo=0.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=FFFF_FFFD, hi=FFFF_FFFF. DIV 8000_0000/FFFF_FFFF → lo=8000_0000, hi=0.
- DIVU FFFF_FFFF/8000_0001 → lo=1, hi=7FFF_FFFE (exercises the hi[31] path).
- DIV 5/0 → lo=FFFF_FFFF, hi=5, DONE at T+1.
- `reset` at T+10 of a MULTU → next cycle `busy_sig`=0, `hi_out`=`lo_out`=0. Separately, `start_sig` pulsed at T+5 is ignored and the original result is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes, HI/LO op encodings and the
// multiply/divide sequencer state type.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Bit 1 selects divide, bit 0 selects signed.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_ITER   = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/ALU.sv
// The core's combinational 32-bit ALU; the sequencer only issues add and sub.
module ALU
    import mips_pkg::*;
(
    input  logic [3:0]  ALU_Control_sig,
    input  logic [31:0] data_1,
    input  logic [31:0] data_2,
    output logic [31:0] ALU_result,
    output logic        zero_sig
);

    // Operation select; unknown codes produce zero.
    always_comb begin
        ALU_result = 32'd0;
        case (ALU_Control_sig)
            ALU_AND: ALU_result = data_1 & data_2;
            ALU_OR:  ALU_result = data_1 | data_2;
            ALU_ADD: ALU_result = data_1 + data_2;
            ALU_SUB: ALU_result = data_1 - data_2;
            ALU_SLT: ALU_result = {31'd0, $signed(data_1) < $signed(data_2)};
            ALU_NOR: ALU_result = ~(data_1 | data_2);
            default: ALU_result = 32'd0;
        endcase
    end

    assign zero_sig = (ALU_result == 32'd0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit. All arithmetic goes through the one
// shared ALU: 32 shift-add / restoring-divide steps plus sign fix-up steps
// for signed ops, so latency is fixed per op class.
// Handshake: start_sig is taken only while idle (busy_sig low); done_sig
// pulses for one cycle with hi_out/lo_out valid, and they hold afterwards.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_sig,
    input  logic [1:0]       op_sig,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy_sig,
    output logic             done_sig,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    seq_state_t r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;          // multiplicand M / dividend, magnitude after NEG_A
    logic [31:0] r_b;          // multiplier / divisor D, magnitude after NEG_B
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic        r_lo_was_zero;

    logic [3:0]  w_alu_ctl;
    logic [31:0] w_alu_d1;
    logic [31:0] w_alu_d2;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;
    logic        w_is_mult;
    logic        w_neg_res;
    logic [31:0] w_shift;
    logic        w_carry;
    logic        w_ge;
    logic [31:0] w_hi_iter;
    logic [31:0] w_lo_iter;
    logic [31:0] w_b_abs;
    logic [31:0] w_hi_fix;

    assign w_is_mult = ~r_op[1];
    assign w_neg_res = r_sign_a ^ r_sign_b;
    assign w_shift   = {r_hi[30:0], r_lo[31]};
    assign w_carry   = (w_alu_res < r_hi);
    assign w_b_abs   = r_sign_b ? w_alu_res : r_b;
    assign w_hi_fix  = (w_is_mult ? w_neg_res : r_sign_a) ? w_alu_res : r_hi;

    ALU u_alu (
        .ALU_Control_sig (w_alu_ctl),
        .data_1          (w_alu_d1),
        .data_2          (w_alu_d2),
        .ALU_result      (w_alu_res),
        .zero_sig        (w_alu_zero)
    );

    // ALU operands per state; the ALU is driven even when a result is discarded.
    always_comb begin
        w_alu_ctl = ALU_ADD;
        w_alu_d1  = 32'd0;
        w_alu_d2  = 32'd0;
        case (r_state)
            S_NEG_A: begin
                w_alu_ctl = ALU_SUB;
                w_alu_d2  = r_a;
            end
            S_NEG_B: begin
                w_alu_ctl = ALU_SUB;
                w_alu_d2  = r_b;
            end
            S_ITER: begin
                if (w_is_mult) begin
                    w_alu_ctl = ALU_ADD;
                    w_alu_d1  = r_hi;
                    w_alu_d2  = r_lo[0] ? r_a : 32'd0;
                end else begin
                    w_alu_ctl = ALU_SUB;
                    w_alu_d1  = w_shift;
                    w_alu_d2  = r_b;
                end
            end
            S_NEG_LO: begin
                w_alu_ctl = ALU_SUB;
                w_alu_d2  = r_lo;
            end
            S_NEG_HI: begin
                if (w_is_mult) begin
                    // Two's complement of the upper word: ~hi plus the borrow out of lo.
                    w_alu_ctl = ALU_ADD;
                    w_alu_d1  = ~r_hi;
                    w_alu_d2  = {31'd0, r_lo_was_zero};
                end else begin
                    w_alu_ctl = ALU_SUB;
                    w_alu_d2  = r_hi;
                end
            end
            default: begin
                w_alu_ctl = ALU_ADD;
            end
        endcase
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    always_comb begin
        w_ge      = 1'b0;
        w_hi_iter = 32'd0;
        w_lo_iter = 32'd0;
        if (w_is_mult) begin
            w_hi_iter = {w_carry, w_alu_res[31:1]};
            w_lo_iter = {w_alu_res[0], r_lo[31:1]};
        end else begin
            // hi[31] set means the shifted remainder is >= 2^32 > D.
            w_ge      = r_hi[31] | (w_shift >= r_b);
            w_hi_iter = w_ge ? w_alu_res : w_shift;
            w_lo_iter = {r_lo[30:0], w_ge};
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= OP_MULTU;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_cnt         <= 6'd0;
            r_lo_was_zero <= 1'b0;
            busy_sig      <= 1'b0;
            done_sig      <= 1'b0;
            hi_out        <= '0;
            lo_out        <= '0;
        end else begin
            done_sig <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_sig) begin
                        r_op     <= op_sig;
                        r_a      <= operand_a;
                        r_b      <= operand_b;
                        r_sign_a <= operand_a[31];
                        r_sign_b <= operand_b[31];
                        r_hi     <= 32'd0;
                        r_lo     <= op_sig[1] ? operand_a : operand_b;
                        r_cnt    <= 6'd0;
                        busy_sig <= 1'b1;
                        if (op_sig[1] && (operand_b == 32'd0)) begin
                            hi_out   <= operand_a;
                            lo_out   <= 32'hFFFF_FFFF;
                            done_sig <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (op_sig[0]) begin
                            r_state <= S_NEG_A;
                        end else begin
                            r_state <= S_ITER;
                        end
                    end
                end
                S_NEG_A: begin
                    if (r_sign_a) r_a <= w_alu_res;
                    r_state <= S_NEG_B;
                end
                S_NEG_B: begin
                    r_b     <= w_b_abs;
                    r_hi    <= 32'd0;
                    r_lo    <= w_is_mult ? w_b_abs : r_a;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_hi <= w_hi_iter;
                    r_lo <= w_lo_iter;
                    if (r_cnt == 6'd31) begin
                        r_cnt <= 6'd0;
                        if (r_op[0]) begin
                            r_state <= S_NEG_LO;
                        end else begin
                            hi_out   <= w_hi_iter;
                            lo_out   <= w_lo_iter;
                            done_sig <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_NEG_LO: begin
                    if (w_neg_res) r_lo <= w_alu_res;
                    // 0 - lo is zero exactly when lo was zero.
                    r_lo_was_zero <= w_alu_zero;
                    r_state       <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    r_hi     <= w_hi_fix;
                    hi_out   <= w_hi_fix;
                    lo_out   <= r_lo;
                    done_sig <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    busy_sig <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    busy_sig <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO results, latency,
// busy/done framing, reset abort and start-while-busy rejection.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start_sig;
    logic [1:0]  op_sig;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy_sig;
    logic        done_sig;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks;
    int n_fail;
    logic [63:0] exp_q[$];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_sig (start_sig),
        .op_sig    (op_sig),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy_sig  (busy_sig),
        .done_sig  (done_sig),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op at cycle T and follow it to completion. poke_at > 0 pulses
    // a conflicting start at T+poke_at; reset_at > 0 resets at T+reset_at.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input int poke_at, input int reset_at);
        int lat;
        logic [63:0] exp_v;
        if (reset_at == 0) exp_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        start_sig = 1'b1;
        op_sig    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start_sig = 1'b0;
        lat = 1;
        check_eq({tag, "_busy_t1"}, {63'd0, busy_sig}, 64'd1);
        while (!done_sig && lat < 60) begin
            if (lat == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                check_eq({tag, "_rst_busy"}, {63'd0, busy_sig}, 64'd0);
                check_eq({tag, "_rst_done"}, {63'd0, done_sig}, 64'd0);
                check_eq({tag, "_rst_hilo"}, {hi_out, lo_out}, 64'd0);
                return;
            end
            if (lat == poke_at) begin
                start_sig = 1'b1;
                op_sig    = 2'b11;
                operand_a = 32'h0000_0063;
                operand_b = 32'h0000_0005;
            end else begin
                start_sig = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start_sig = 1'b0;
        check_eq({tag, "_latency"}, lat, exp_lat);
        exp_v = exp_q.pop_front();
        check_eq({tag, "_hilo"}, {hi_out, lo_out}, exp_v);
        check_eq({tag, "_busy_done"}, {63'd0, busy_sig}, 64'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_idle"}, {62'd0, busy_sig, done_sig}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_hold"}, {hi_out, lo_out}, exp_v);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start_sig = 1'b0;
        op_sig    = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy_done", {62'd0, busy_sig, done_sig}, 64'd0);
        check_eq("reset_hilo", {hi_out, lo_out}, 64'd0);
        reset = 1'b0;

        run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0, 0);
        run_op("mult_m3x7",  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 37, 0, 0);
        run_op("mult_m1x0",  2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 37, 0, 0);
        run_op("divu_100_7", 2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        33, 0, 0);
        run_op("div_m7_2",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 0, 0);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 37, 0, 0);
        run_op("divu_hi31",  2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 33, 0, 0);
        run_op("div_by0",    2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1,  0, 0);
        run_op("multu_rst",  2'b00, 32'h1234_5678, 32'h0000_0009, 32'h0,         32'h0,         33, 0, 10);
        run_op("multu_poke", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 33, 5, 0);
        run_op("mult_mxm",   2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 37, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
